// File: rtl/ram_read_stream.sv
// ---------------------------------------------------------------------------
// ram_read_stream
//
// Read engine placed directly in front of a single_port_RAM instance. A
// (base_addr, len) command is accepted in IDLE. The engine then issues one
// read address per cycle while buffer credit is available. Returning words
// are caught in a small circular holding buffer, which absorbs the RAM's
// fixed read latency. The words leave the buffer as a valid/ready stream,
// and the final word of the transfer is flagged with dout_last.
//
// Optional feature macro: RAM_READ_STREAM_ABORT_EN
//   When defined, an 'abort' input is added. Asserting it in READ or DRAIN
//   flushes the buffer and the in-flight reads, and goes straight to DONE.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       command strobe, only honoured in IDLE
//   base_addr   first word address of the transfer
//   len         number of words to read (0 is legal)
//   busy        high while in READ or DRAIN
//   done        one-cycle completion pulse
//   ram_addr    registered RAM read address
//   ram_wr_en   tied low, this block never writes the RAM
//   ram_dout    RAM read data, valid RD_LATENCY cycles after ram_addr
//   dout        stream data (buffer head), zero when dout_valid is low
//   dout_valid  stream valid
//   dout_ready  consumer ready
//   dout_last   head word is the final word of the transfer
//   abort       (RAM_READ_STREAM_ABORT_EN only) cancel the transfer
// ---------------------------------------------------------------------------
module ram_read_stream #(
  parameter int DATA_WIDTH   = 8,
  parameter int RAM_DEPTH    = 256,
  parameter int LB_RAM_DEPTH = $clog2(RAM_DEPTH),
  parameter int RD_LATENCY   = 2,
  parameter int BUF_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LB_RAM_DEPTH-1:0] base_addr,
  input  logic [LB_RAM_DEPTH:0]   len,
  output logic                    busy,
  output logic                    done,
  output logic [LB_RAM_DEPTH-1:0] ram_addr,
  output logic                    ram_wr_en,
  input  logic [DATA_WIDTH-1:0]   ram_dout,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last
`ifdef RAM_READ_STREAM_ABORT_EN
  ,
  input  logic                    abort
`endif
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [LB_RAM_DEPTH-1:0] ADDR_MAX = LB_RAM_DEPTH'(RAM_DEPTH - 1);
  localparam logic [LB_RAM_DEPTH-1:0] ADDR_ONE = LB_RAM_DEPTH'(1);
  localparam logic [LB_RAM_DEPTH:0]   REM_ONE  = (LB_RAM_DEPTH + 1)'(1);
  localparam logic [PTR_W-1:0]        PTR_MAX  = PTR_W'(BUF_DEPTH - 1);
  localparam logic [PTR_W-1:0]        PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]        CNT_FULL = CNT_W'(BUF_DEPTH);

  logic [1:0]              state;
  logic [LB_RAM_DEPTH:0]   remaining;
  logic [LB_RAM_DEPTH-1:0] addr_next;

  logic [RD_LATENCY-1:0]   tag_vld;
  logic [RD_LATENCY-1:0]   tag_last;
  logic [CNT_W-1:0]        inflight;
  logic [CNT_W-1:0]        count;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [DATA_WIDTH-1:0]   buf_data [BUF_DEPTH];
  logic                    buf_last [BUF_DEPTH];

  logic issue;
  logic push;
  logic pop;
  logic abort_hit;

  // Abort is only meaningful while a transfer is running; in IDLE and DONE
  // it is ignored. Without the feature macro the flush path is tied off.
`ifdef RAM_READ_STREAM_ABORT_EN
  assign abort_hit = abort && ((state == ST_READ) || (state == ST_DRAIN));
`else
  assign abort_hit = 1'b0;
`endif

  // ram_addr always holds the next address to read. An issue happens in the
  // cycle that address is on the bus and credit is available. A cycle
  // without credit still presents an address to the RAM, but no tag
  // follows it, so the returned word is never captured. Credit uses only
  // registered occupancy, so a pop in the same cycle does not free a slot.
  assign issue = (state == ST_READ) && (remaining != '0) &&
                 ((int'(count) + int'(inflight)) < BUF_DEPTH);

  assign push = tag_vld[RD_LATENCY-1];
  assign pop  = dout_valid && dout_ready;

  // Explicit wrap, because RAM_DEPTH need not be a power of two.
  assign addr_next = (ram_addr == ADDR_MAX) ? '0 : ram_addr + ADDR_ONE;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + PTR_ONE;
  endfunction

  // Control FSM. The command is latched on acceptance, and the first
  // address goes straight onto the bus so that it is issued in cycle 1.
  // READ counts words down and hands over to DRAIN after the final
  // address. DRAIN waits for the consumer to take the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      remaining <= '0;
      ram_addr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            ram_addr  <= base_addr;
            remaining <= len;
            state     <= (len == '0) ? ST_DONE : ST_READ;
          end
        end
        ST_READ: begin
          if (abort_hit) begin
            remaining <= '0;
            state     <= ST_DONE;
          end else if (issue) begin
            ram_addr  <= addr_next;
            remaining <= remaining - REM_ONE;
            if (remaining == REM_ONE) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (abort_hit) begin
            state <= ST_DONE;
          end else if (pop && dout_last) begin
            state <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Issue tags travel alongside the RAM pipeline. When a tag leaves the
  // final stage, ram_dout holds the matching word and it is pushed into
  // the buffer. inflight tracks tags still in the pipe, and count tracks
  // the buffer occupancy. Together they form the credit check. An abort
  // clears all of this state, so words still in the RAM pipe are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld  <= '0;
      tag_last <= '0;
      inflight <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (abort_hit) begin
      tag_vld  <= '0;
      tag_last <= '0;
      inflight <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      tag_vld[0]  <= issue;
      tag_last[0] <= issue && (remaining == REM_ONE);
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_last[i] <= tag_last[i-1];
      end

      if (issue && !push) begin
        inflight <= inflight + CNT_ONE;
      end else if (!issue && push) begin
        inflight <= inflight - CNT_ONE;
      end

      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (!push && pop) begin
        count <= count - CNT_ONE;
      end

      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  // Buffer storage needs no reset. Only entries between rd_ptr and wr_ptr
  // are ever observed, and dout is masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= ram_dout;
      buf_last[wr_ptr] <= tag_last[RD_LATENCY-1];
    end
  end

  // The stream outputs come from the buffer head only. dout_valid therefore
  // never depends on dout_ready, and the head holds until it is taken.
  assign dout_valid = (count != '0);
  assign dout       = dout_valid ? buf_data[rd_ptr] : '0;
  assign dout_last  = dout_valid && buf_last[rd_ptr];

  assign busy      = (state == ST_READ) || (state == ST_DRAIN);
  assign done      = (state == ST_DONE);
  assign ram_wr_en = 1'b0;

  // The credit rule guarantees that a push never lands on a full buffer.
  // The checks below would fire if that guarantee were ever broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == CNT_FULL)));

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (int'(count) <= BUF_DEPTH));

endmodule

// File: tb/tb_ram_read_stream.sv
// ---------------------------------------------------------------------------
// tb_ram_read_stream
//
// Testbench for ram_read_stream. The DUT is built with RAM_DEPTH=200 so that
// the non-power-of-two address wrap is exercised. A two-stage RAM model
// returns data_of(addr) for every address. Each command pushes its expected
// words into a scoreboard queue, and an independent monitor pops and
// compares every word the DUT presents.
// ---------------------------------------------------------------------------
module tb_ram_read_stream;

  localparam int DW    = 8;
  localparam int DEPTH = 200;
  localparam int LB    = 8;
  localparam int BUFD  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LB-1:0] base_addr = '0;
  logic [LB:0]   len = '0;
  logic          busy;
  logic          done;
  logic [LB-1:0] ram_addr;
  logic          ram_wr_en;
  logic [DW-1:0] ram_dout = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic          dout_last;
`ifdef RAM_READ_STREAM_ABORT_EN
  logic          abort = 1'b0;
`endif

  int checks = 0;
  int passes = 0;

  logic [DW:0] exp_q [$];

  ram_read_stream #(
    .DATA_WIDTH(DW),
    .RAM_DEPTH(DEPTH),
    .LB_RAM_DEPTH(LB),
    .RD_LATENCY(2),
    .BUF_DEPTH(BUFD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .base_addr(base_addr),
    .len(len),
    .busy(busy),
    .done(done),
    .ram_addr(ram_addr),
    .ram_wr_en(ram_wr_en),
    .ram_dout(ram_dout),
    .dout(dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_last(dout_last)
`ifdef RAM_READ_STREAM_ABORT_EN
    ,
    .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  // Contents of the RAM model: 7 is odd, so every address maps to a
  // distinct byte, and an address that fails to wrap returns the wrong data.
  function automatic logic [DW-1:0] data_of(input int a);
    return DW'((a * 7 + 3) % 256);
  endfunction

  // single_port_RAM model: the address is registered, then the data is
  // registered, so words appear two cycles after the address.
  logic [DW-1:0] ram_stage = '0;
  always @(posedge clk) begin
    ram_stage <= data_of(int'(ram_addr));
    ram_dout  <= ram_stage;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every cycle with dout_valid high is compared with the head of
  // the scoreboard. This also checks that the head holds steady while it
  // is stalled. An entry is removed only on a handshake.
  always @(negedge clk) begin
    if (rst_n && dout_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_word: got dout=%0d last=%0d, expected no word",
                 dout, dout_last);
      end else begin
        checkOutput("word_data", int'(dout), int'(exp_q[0][DW-1:0]));
        checkOutput("word_last", int'(dout_last), int'(exp_q[0][DW]));
        if (dout_ready) begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Presents a command for one cycle and records the words it should
  // produce. On return the bench sits in cycle 1 of the transfer.
  task automatic applyStimulus(input int base, input int n);
    start     = 1'b1;
    base_addr = LB'(base);
    len       = (LB + 1)'(n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({(i == n - 1), data_of((base + i) % DEPTH)});
    end
    next_cycle();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!done && k < 100) begin
      next_cycle();
      k++;
    end
    checkOutput(name, int'(done), 1);
  endtask

  // Watchdog so that the run always ends, even if the main sequence stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] ram_read_stream bench starting");

    // Reset state
    next_cycle();
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_valid", int'(dout_valid), 0);
    checkOutput("rst_last", int'(dout_last), 0);
    checkOutput("rst_addr", int'(ram_addr), 0);
    checkOutput("rst_dout", int'(dout), 0);
    checkOutput("rst_wr_en", int'(ram_wr_en), 0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    next_cycle();

    // Basic transfer: base 10, len 5. The words appear in cycles 4..8 and
    // done pulses in cycle 9.
    dout_ready = 1'b1;
    applyStimulus(10, 5);
    checkOutput("t1_first_addr", int'(ram_addr), 10);
    for (int c = 1; c <= 10; c++) begin
      checkOutput($sformatf("t1_busy_c%0d", c), int'(busy), int'(c >= 1 && c <= 8));
      checkOutput($sformatf("t1_valid_c%0d", c), int'(dout_valid), int'(c >= 4 && c <= 8));
      checkOutput($sformatf("t1_done_c%0d", c), int'(done), int'(c == 9));
      if (c < 10) next_cycle();
    end
    checkOutput("t1_sb_empty", exp_q.size(), 0);
    next_cycle();

    // Address wrap at the non-power-of-two depth: 198, 199, 0, 1
    applyStimulus(198, 4);
    wait_done("t2_done");
    next_cycle();
    checkOutput("t2_sb_empty", exp_q.size(), 0);

    // Back-pressure: with the consumer stalled, only BUF_DEPTH reads may be
    // issued, so ram_addr rests at base+4.
    dout_ready = 1'b0;
    applyStimulus(50, 8);
    repeat (9) next_cycle();
    checkOutput("t3_issued_addr", int'(ram_addr), 54);
    checkOutput("t3_valid_held", int'(dout_valid), 1);
    checkOutput("t3_busy", int'(busy), 1);
    dout_ready = 1'b1;
    wait_done("t3_done");
    next_cycle();
    checkOutput("t3_sb_empty", exp_q.size(), 0);

    // Zero-length command: done in cycle 1, busy never set, no words
    applyStimulus(33, 0);
    checkOutput("t4_len0_done", int'(done), 1);
    checkOutput("t4_len0_busy", int'(busy), 0);
    checkOutput("t4_len0_valid", int'(dout_valid), 0);
    next_cycle();
    checkOutput("t4_len0_done_clr", int'(done), 0);
    checkOutput("t4_len0_valid2", int'(dout_valid), 0);

    // A start issued while busy is ignored, so no extra words may appear.
    applyStimulus(100, 3);
    next_cycle();
    start     = 1'b1;
    base_addr = LB'(5);
    len       = (LB + 1)'(6);
    next_cycle();
    start = 1'b0;
    checkOutput("t4_busy_mid", int'(busy), 1);
    wait_done("t4_done");
    next_cycle();
    repeat (6) next_cycle();
    checkOutput("t4_sb_empty", exp_q.size(), 0);
    checkOutput("t4_idle", int'(busy), 0);

    // Reset mid-transfer after three words have been taken
    applyStimulus(20, 8);
    repeat (6) next_cycle();
    checkOutput("t5_words_left", exp_q.size(), 5);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_busy", int'(busy), 0);
    checkOutput("t5_rst_done", int'(done), 0);
    checkOutput("t5_rst_valid", int'(dout_valid), 0);
    checkOutput("t5_rst_last", int'(dout_last), 0);
    checkOutput("t5_rst_dout", int'(dout), 0);
    checkOutput("t5_rst_addr", int'(ram_addr), 0);
    exp_q.delete();
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    applyStimulus(120, 3);
    wait_done("t5_done");
    next_cycle();
    repeat (4) next_cycle();
    checkOutput("t5_sb_empty", exp_q.size(), 0);

`ifdef RAM_READ_STREAM_ABORT_EN
    // Abort in cycle 5 of a 16-word transfer. The consumer holds off in
    // that cycle so that only word 0 is taken.
    applyStimulus(60, 16);
    repeat (3) next_cycle();
    next_cycle();
    abort      = 1'b1;
    dout_ready = 1'b0;
    next_cycle();
    abort      = 1'b0;
    dout_ready = 1'b1;
    checkOutput("t6_abort_done", int'(done), 1);
    checkOutput("t6_abort_valid", int'(dout_valid), 0);
    checkOutput("t6_abort_busy", int'(busy), 0);
    exp_q.delete();
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      checkOutput($sformatf("t6_quiet_valid_%0d", c), int'(dout_valid), 0);
    end
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    checkOutput("t6_idle_abort_done", int'(done), 0);
    applyStimulus(7, 2);
    wait_done("t6_after_done");
    next_cycle();
    checkOutput("t6_sb_empty", exp_q.size(), 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
